auth_msg_tx_handshake: RTL and testbench
========================================

Name: auth_msg_tx_handshake

Overview:
Driver-side transmitter for authentication response messages sent to the USB host/PD-DEBUG driver. It accepts one MSG_LEN-bit message from the internal authentication responder and checks its protocol-version header. It then requests a response slot from the host (resp_req_out/resp_req_in) and presents the message on auth_msg_out/auth_msg_ready until the host answers with Ack_in_driver. It is the counterpart of the host model, which consumes auth_msg_out and produces Ack_in_driver.

Parameters:
MSG_LEN, 2080, message width: version 8, type 8, param1 8, param2 8, reserved 16, length 16, payload 2016; MSB = version byte.
HDR_VERSION, 8'h01, required value of msg_data[MSG_LEN-1 -: 8].
TIMEOUT_CYCLES, 1024, per-wait timeout in clk cycles (2..65535).
MAX_RETRY, 3, number of SEND attempts before giving up (1..15).

Ports:
clk  input  1  system clock; all logic on posedge.
reset  input  1  synchronous, active-high reset.
msg_valid  input  1  responder offers msg_data.
msg_data  input  MSG_LEN  message to transmit.
msg_accept  output  1  high in IDLE only; transfer occurs when msg_valid & msg_accept.
resp_req_out  output  1  request to host for a response slot.
resp_req_in  input  1  host grant, active-low (host drives 1 at idle and 0 when it grants).
auth_msg_out  output  MSG_LEN  latched message to host.
auth_msg_ready  output  1  auth_msg_out valid.
Ack_in_driver  input  1  host acknowledge (level).
busy  output  1  state != IDLE.
tx_done  output  1  one-cycle pulse on successful completion.
tx_error  output  1  one-cycle pulse on failure.
err_code  output  2  01 bad version, 10 ack timeout/retries exhausted, 11 grant timeout; held until next tx_error or reset.
retry_cnt  output  4  SEND attempts used by the current/last message.

Behaviour:
- Reset: state IDLE; msg_accept=1; resp_req_out, auth_msg_ready, busy, tx_done, tx_error=0; auth_msg_out=0; err_code=00; retry_cnt=0; timer=0. Reset in any state aborts the transfer at the next edge with no tx_done or tx_error pulse.
- Timer: 16-bit, cleared on every state change. A wait times out when timer == TIMEOUT_CYCLES-1 and the awaited condition is false that same cycle. If the condition is true in the same cycle, the condition wins.
- IDLE: on transfer, latch msg_data into auth_msg_out and set retry_cnt=0.
  - If the version byte != HDR_VERSION, go to IDLE and pulse tx_error with err_code=01 in the next cycle. resp_req_out never rises.
  - Otherwise go to REQ.
- REQ: resp_req_out=1.
  - If resp_req_in==0, go to SEND; auth_msg_ready rises in the next cycle.
  - On timeout, go to IDLE with tx_error and err_code=11.
- SEND: resp_req_out=1, auth_msg_ready=1, auth_msg_out held stable. retry_cnt increments on entry.
  - If Ack_in_driver==1, go to RELEASE.
  - On timeout: if retry_cnt==MAX_RETRY, go to IDLE with tx_error and err_code=10. Otherwise go to BACKOFF.
- BACKOFF: auth_msg_ready=0, resp_req_out=1. Hold exactly 2 cycles, then return to SEND.
- RELEASE: auth_msg_ready=0, resp_req_out=0.
  - If Ack_in_driver==0, go to IDLE and pulse tx_done.
  - On timeout, go to IDLE with tx_error and err_code=10.
- Latency:
  - Transfer at cycle N gives resp_req_out=1 at N+1.
  - Grant sampled at M gives auth_msg_ready=1 at M+1.
  - Ack sampled at K gives auth_msg_ready=0 at K+1.
  - Ack low sampled at L gives tx_done=1 and msg_accept=1 at L+1.
  - Best-case cycle-count, with the host model acking one cycle after ready: transfer to tx_done in 5 cycles.
- Ack_in_driver already high on entry to SEND is accepted immediately. An Ack seen in REQ or BACKOFF is ignored.
- A resp_req_in rising back to 1 during SEND is ignored; the grant is sampled only in REQ.
- tx_done and tx_error are never high together. msg_accept=0 whenever busy=1.

Test Plan:
1. Reset 4 cycles, then msg_valid with header {01,82,00,00,0000,0103}. Host grants 1 cycle after resp_req_out and acks 1 cycle after ready -> tx_done 5 cycles after transfer, retry_cnt=1, auth_msg_out equals msg_data bit-exact while ready=1.
2. Version byte 8'h02 -> tx_error the next cycle, err_code=01, resp_req_out never 1, msg_accept stays 1.
3. TIMEOUT_CYCLES=16 with resp_req_in held 1 -> tx_error exactly 16 cycles after REQ entry, err_code=11, resp_req_out low the same cycle.
4. TIMEOUT_CYCLES=16, MAX_RETRY=3, Ack never asserted -> three ready windows of 16 cycles each, separated by 2-cycle gaps. Then tx_error, err_code=10, retry_cnt=3.
5. Ack absent on attempt 1 and asserted on attempt 2 -> tx_done, retry_cnt=2; auth_msg_out identical across both windows.
6. reset asserted mid-SEND -> the next cycle has all outputs at reset values with no tx_done or tx_error. A following message completes normally.

Source files
------------

// File: rtl/auth_msg_tx_handshake.sv
// Authentication response transmitter: header check, slot request,
// message presentation with ack/timeout/retry handling toward the host.
module auth_msg_tx_handshake #(
  parameter int          MSG_LEN        = 2080,
  parameter logic [7:0]  HDR_VERSION    = 8'h01,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter int          MAX_RETRY      = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               msg_valid,
  input  logic [MSG_LEN-1:0] msg_data,
  output logic               msg_accept,
  output logic               resp_req_out,
  input  logic               resp_req_in,
  output logic [MSG_LEN-1:0] auth_msg_out,
  output logic               auth_msg_ready,
  input  logic               Ack_in_driver,
  output logic               busy,
  output logic               tx_done,
  output logic               tx_error,
  output logic [1:0]         err_code,
  output logic [3:0]         retry_cnt
);

  typedef enum logic [2:0] {
    IDLE, REQ, SEND, BACKOFF, RELEASE
  } state_t;

  localparam logic [15:0] T_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  R_MAX  = 4'(MAX_RETRY);

  state_t      state, state_d;
  logic [15:0] timer;
  logic [3:0]  retry_d;
  logic [1:0]  code_d;
  logic        done_d, err_d, load;
  logic        tmo;

  assign tmo            = (timer == T_LAST);
  assign msg_accept     = (state == IDLE);
  assign busy           = (state != IDLE);
  assign auth_msg_ready = (state == SEND);
  assign resp_req_out   = (state == REQ) || (state == SEND) ||
                          (state == BACKOFF);

  always_comb begin
    state_d = state;
    retry_d = retry_cnt;
    code_d  = err_code;
    done_d  = 1'b0;
    err_d   = 1'b0;
    load    = 1'b0;
    unique case (state)
      IDLE: if (msg_valid) begin
        load    = 1'b1;
        retry_d = 4'd0;
        if (msg_data[MSG_LEN-1 -: 8] != HDR_VERSION) begin
          err_d  = 1'b1;
          code_d = 2'b01;
        end else begin
          state_d = REQ;
        end
      end
      REQ: if (!resp_req_in) begin
        state_d = SEND;
        retry_d = retry_cnt + 4'd1;
      end else if (tmo) begin
        state_d = IDLE;
        err_d   = 1'b1;
        code_d  = 2'b11;
      end
      SEND: if (Ack_in_driver) begin
        state_d = RELEASE;
      end else if (tmo) begin
        if (retry_cnt == R_MAX) begin
          state_d = IDLE;
          err_d   = 1'b1;
          code_d  = 2'b10;
        end else begin
          state_d = BACKOFF;
        end
      end
      // fixed two-cycle gap between send attempts
      BACKOFF: if (timer == 16'd1) begin
        state_d = SEND;
        retry_d = retry_cnt + 4'd1;
      end
      RELEASE: if (!Ack_in_driver) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else if (tmo) begin
        state_d = IDLE;
        err_d   = 1'b1;
        code_d  = 2'b10;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      timer        <= 16'd0;
      retry_cnt    <= 4'd0;
      err_code     <= 2'b00;
      tx_done      <= 1'b0;
      tx_error     <= 1'b0;
      auth_msg_out <= '0;
    end else begin
      state     <= state_d;
      timer     <= (state_d != state) ? 16'd0 : timer + 16'd1;
      retry_cnt <= retry_d;
      err_code  <= code_d;
      tx_done   <= done_d;
      tx_error  <= err_d;
      if (load) auth_msg_out <= msg_data;
    end
  end

endmodule

// File: tb/tb_auth_msg_tx_handshake.sv
// Directed bench for auth_msg_tx_handshake with a cycle-level host
// model; TIMEOUT_CYCLES=16, MAX_RETRY=3.
module tb_auth_msg_tx_handshake;

  localparam int ML = 2080;

  logic          clk = 1'b0;
  logic          reset;
  logic          msg_valid;
  logic [ML-1:0] msg_data;
  logic          msg_accept;
  logic          resp_req_out;
  logic          resp_req_in;
  logic [ML-1:0] auth_msg_out;
  logic          auth_msg_ready;
  logic          Ack_in_driver;
  logic          busy;
  logic          tx_done;
  logic          tx_error;
  logic [1:0]    err_code;
  logic [3:0]    retry_cnt;

  auth_msg_tx_handshake #(
    .MSG_LEN(ML), .HDR_VERSION(8'h01),
    .TIMEOUT_CYCLES(16), .MAX_RETRY(3)
  ) dut (
    .clk(clk), .reset(reset),
    .msg_valid(msg_valid), .msg_data(msg_data),
    .msg_accept(msg_accept),
    .resp_req_out(resp_req_out), .resp_req_in(resp_req_in),
    .auth_msg_out(auth_msg_out), .auth_msg_ready(auth_msg_ready),
    .Ack_in_driver(Ack_in_driver), .busy(busy),
    .tx_done(tx_done), .tx_error(tx_error),
    .err_code(err_code), .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic [7:0] ver;
    bit         grant;
    int         ack_att;
    bit         exp_done;
    logic [1:0] exp_code;
    int         exp_cyc;
    int         exp_retry;
    bit         exp_req;
  } vec_t;

  function automatic logic [ML-1:0] make_msg(input logic [7:0] ver);
    logic [ML-1:0] m;
    for (int i = 0; i < ML / 32; i++) m[i*32 +: 32] = $urandom;
    m[ML-1 -: 64] = {ver, 8'h82, 16'h0000, 16'h0000, 16'h0103};
    return m;
  endfunction

  // Offers one message, then plays the host: grant one cycle after the
  // request is seen, ack one cycle after ready on attempt ack_att only.
  task automatic run(input logic [7:0] ver, input bit grant,
                     input int ack_att,
                     output int cyc, output bit done, output bit err,
                     output logic [1:0] code, output int rc,
                     output int nwin, output bit req_seen,
                     output bit stable_ok, output bit inv_ok,
                     output bit win_ok, output bit req_end);
    logic [ML-1:0] m;
    bit prev_req, prev_rdy, acked;
    int att, len, gap;
    m = make_msg(ver);
    cyc = -1; done = 0; err = 0; code = 2'b00; rc = -1; nwin = -1;
    req_seen = 0; stable_ok = 1; inv_ok = 1; win_ok = 1; req_end = 1;
    prev_req = 0; prev_rdy = 0; acked = 0; att = 0; len = 0; gap = 0;
    @(negedge clk);
    msg_valid = 1'b1; msg_data = m;
    resp_req_in = 1'b1; Ack_in_driver = 1'b0;
    @(posedge clk);
    #1 msg_valid = 1'b0; msg_data = '0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (tx_done && tx_error) inv_ok = 0;
      if (msg_accept == busy) inv_ok = 0;
      if (resp_req_out) req_seen = 1;
      if (auth_msg_ready && auth_msg_out !== m) stable_ok = 0;
      if (auth_msg_ready && !prev_rdy) begin
        att++;
        if (att > 1 && gap != 2) win_ok = 0;
        len = 0; acked = 0;
      end
      if (!auth_msg_ready && prev_rdy) begin
        if (!acked && len != 16) win_ok = 0;
        gap = 0;
      end
      if (auth_msg_ready) len++; else gap++;
      if (tx_done || tx_error) begin
        cyc = n; done = tx_done; err = tx_error; code = err_code;
        rc = int'(retry_cnt); nwin = att; req_end = resp_req_out;
        break;
      end
      resp_req_in   = !(grant && resp_req_out && prev_req);
      Ack_in_driver = auth_msg_ready && prev_rdy && (att == ack_att);
      if (Ack_in_driver) acked = 1;
      prev_req = resp_req_out;
      prev_rdy = auth_msg_ready;
    end
    resp_req_in = 1'b1;
    Ack_in_driver = 1'b0;
  endtask

  vec_t vt[8];

  initial begin
    int cyc, rc, nwin;
    bit done, err, req_seen, stable_ok, inv_ok, win_ok, req_end, seen;
    logic [1:0] code;
    string tag;

    vt[0] = '{8'h01, 1'b1, 1, 1'b1, 2'b00,  5, 1, 1'b1};
    vt[1] = '{8'h02, 1'b1, 1, 1'b0, 2'b01,  0, 0, 1'b0};
    vt[2] = '{8'h01, 1'b0, 1, 1'b0, 2'b11, 16, 0, 1'b1};
    vt[3] = '{8'h01, 1'b1, 0, 1'b0, 2'b10, 54, 3, 1'b1};
    vt[4] = '{8'h01, 1'b1, 2, 1'b1, 2'b00, 23, 2, 1'b1};
    vt[5] = '{8'h01, 1'b1, 3, 1'b1, 2'b00, 41, 3, 1'b1};
    vt[6] = '{8'h00, 1'b1, 1, 1'b0, 2'b01,  0, 0, 1'b0};
    vt[7] = '{8'h81, 1'b1, 1, 1'b0, 2'b01,  0, 0, 1'b0};

    reset = 1'b1; msg_valid = 1'b0; msg_data = '0;
    resp_req_in = 1'b1; Ack_in_driver = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_accept", 64'(msg_accept), 64'd1);
    chk("rst_req", 64'(resp_req_out), 64'd0);
    chk("rst_ready", 64'(auth_msg_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_pulses", 64'({tx_done, tx_error}), 64'd0);
    chk("rst_msg_zero", 64'(auth_msg_out == '0), 64'd1);
    chk("rst_code", 64'(err_code), 64'd0);
    chk("rst_retry", 64'(retry_cnt), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run(vt[i].ver, vt[i].grant, vt[i].ack_att, cyc, done, err, code,
          rc, nwin, req_seen, stable_ok, inv_ok, win_ok, req_end);
      tag = $sformatf("v%0d", i);
      chk({tag, "_done"}, 64'({done, err}), 64'({vt[i].exp_done,
                                               !vt[i].exp_done}));
      if (!vt[i].exp_done) chk({tag, "_code"}, 64'(code),
                               64'(vt[i].exp_code));
      chk({tag, "_cycles"}, 64'(cyc), 64'(vt[i].exp_cyc));
      chk({tag, "_retry"}, 64'(rc), 64'(vt[i].exp_retry));
      chk({tag, "_windows"}, 64'(nwin), 64'(vt[i].exp_retry));
      chk({tag, "_req_seen"}, 64'(req_seen), 64'(vt[i].exp_req));
      chk({tag, "_stable"}, 64'(stable_ok), 64'd1);
      chk({tag, "_invariants"}, 64'(inv_ok), 64'd1);
      chk({tag, "_window_len"}, 64'(win_ok), 64'd1);
      chk({tag, "_req_end"}, 64'(req_end), 64'd0);
      @(negedge clk);
      chk({tag, "_pulse_1cyc"}, 64'({tx_done, tx_error}), 64'd0);
    end

    // reset in the middle of a SEND window
    @(negedge clk);
    msg_valid = 1'b1; msg_data = make_msg(8'h01);
    @(posedge clk);
    #1 msg_valid = 1'b0;
    @(negedge clk);
    resp_req_in = 1'b0;
    seen = 0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      seen = auth_msg_ready;
    end
    chk("mid_send_reached", 64'(seen), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    resp_req_in = 1'b1;
    chk("mr_accept", 64'(msg_accept), 64'd1);
    chk("mr_req_ready_busy",
        64'({resp_req_out, auth_msg_ready, busy}), 64'd0);
    chk("mr_pulses", 64'({tx_done, tx_error}), 64'd0);
    chk("mr_code", 64'(err_code), 64'd0);
    chk("mr_retry", 64'(retry_cnt), 64'd0);
    chk("mr_msg_zero", 64'(auth_msg_out == '0), 64'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("mr_no_pulse_after", 64'({tx_done, tx_error}), 64'd0);

    run(8'h01, 1'b1, 1, cyc, done, err, code, rc, nwin, req_seen,
        stable_ok, inv_ok, win_ok, req_end);
    chk("post_rst_done", 64'({done, err}), 64'b10);
    chk("post_rst_cycles", 64'(cyc), 64'd5);
    chk("post_rst_retry", 64'(rc), 64'd1);
    chk("post_rst_stable", 64'(stable_ok), 64'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
